// File: rtl/csr_pkg.sv
// Register map, field widths and reset constants for the csr block.
package csr_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CTRL_W   = 3;
    localparam int unsigned DIM_W    = 8;
    localparam int unsigned IDX_W    = 16;
    localparam int unsigned BUFF_W   = 4;
    localparam int unsigned SCALE_W  = 32;
    localparam int unsigned PKT_W    = 16;
    localparam int unsigned STATUS_W = 3;

    localparam logic [ADDR_W-1:0] CSR_CTRL    = 8'h00;
    localparam logic [ADDR_W-1:0] CSR_M       = 8'h04;
    localparam logic [ADDR_W-1:0] CSR_N       = 8'h08;
    localparam logic [ADDR_W-1:0] CSR_K       = 8'h0C;
    localparam logic [ADDR_W-1:0] CSR_TM      = 8'h10;
    localparam logic [ADDR_W-1:0] CSR_TN      = 8'h14;
    localparam logic [ADDR_W-1:0] CSR_TK      = 8'h18;
    localparam logic [ADDR_W-1:0] CSR_M_IDX   = 8'h1C;
    localparam logic [ADDR_W-1:0] CSR_N_IDX   = 8'h20;
    localparam logic [ADDR_W-1:0] CSR_K_IDX   = 8'h24;
    localparam logic [ADDR_W-1:0] CSR_BUFF    = 8'h28;
    localparam logic [ADDR_W-1:0] CSR_SA      = 8'h2C;
    localparam logic [ADDR_W-1:0] CSR_SW      = 8'h30;
    localparam logic [ADDR_W-1:0] CSR_PKT_LEN = 8'h34;
    localparam logic [ADDR_W-1:0] CSR_CRC_EN  = 8'h38;
    localparam logic [ADDR_W-1:0] CSR_STATUS  = 8'h3C;

    localparam logic [PKT_W-1:0]  PKT_LEN_RST_DEF   = 16'd256;
    localparam logic [DATA_W-1:0] UNMAPPED_DEADBEEF = 32'hDEADBEEF;

endpackage

// File: rtl/csr.sv
// Flat control/status register file with zero-latency write visibility.
// Define CSR_UNMAPPED_DEADBEEF_EN to make unmapped reads return 32'hDEADBEEF instead of 0.
module csr
    import csr_pkg::*;
#(
    parameter logic [PKT_W-1:0] PKT_LEN_RST = PKT_LEN_RST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [DIM_W-1:0]    M,
    output logic [DIM_W-1:0]    N,
    output logic [DIM_W-1:0]    K,
    output logic [DIM_W-1:0]    Tm,
    output logic [DIM_W-1:0]    Tn,
    output logic [DIM_W-1:0]    Tk,
    output logic [IDX_W-1:0]    m_idx,
    output logic [IDX_W-1:0]    n_idx,
    output logic [IDX_W-1:0]    k_idx,
    output logic                bank_sel_wr_A,
    output logic                bank_sel_wr_B,
    output logic                bank_sel_rd_A,
    output logic                bank_sel_rd_B,
    output logic [7:0]          Sa,
    output logic [7:0]          Sw,
    output logic [PKT_W-1:0]    pkt_len_max,
    output logic                crc_en,
    output logic [STATUS_W-1:0] status
);

    logic [CTRL_W-1:0]   ctrl_q;
    logic [DIM_W-1:0]    m_q, n_q, k_q, tm_q, tn_q, tk_q;
    logic [IDX_W-1:0]    m_idx_q, n_idx_q, k_idx_q;
    logic [BUFF_W-1:0]   buff_q;
    logic [SCALE_W-1:0]  sa_q, sw_q;
    logic [PKT_W-1:0]    pkt_len_q;
    logic                crc_en_q;
    logic [STATUS_W-1:0] status_q;
    logic [DATA_W-1:0]   unmapped_val;

    // Reads have no side effects, so the strobe carries no information here.
    logic unused_rd_en;
    assign unused_rd_en = rd_en;

`ifdef CSR_UNMAPPED_DEADBEEF_EN
    assign unmapped_val = UNMAPPED_DEADBEEF;
`else
    assign unmapped_val = '0;
`endif

    // Write decode; unaligned or out-of-map addresses match no item and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            tm_q      <= '0;
            tn_q      <= '0;
            tk_q      <= '0;
            m_idx_q   <= '0;
            n_idx_q   <= '0;
            k_idx_q   <= '0;
            buff_q    <= '0;
            sa_q      <= '0;
            sw_q      <= '0;
            pkt_len_q <= PKT_LEN_RST;
            crc_en_q  <= 1'b0;
            status_q  <= '0;
        end else if (wr_en) begin
            case (addr)
                CSR_CTRL:    ctrl_q    <= wdata[CTRL_W-1:0];
                CSR_M:       m_q       <= wdata[DIM_W-1:0];
                CSR_N:       n_q       <= wdata[DIM_W-1:0];
                CSR_K:       k_q       <= wdata[DIM_W-1:0];
                CSR_TM:      tm_q      <= wdata[DIM_W-1:0];
                CSR_TN:      tn_q      <= wdata[DIM_W-1:0];
                CSR_TK:      tk_q      <= wdata[DIM_W-1:0];
                CSR_M_IDX:   m_idx_q   <= wdata[IDX_W-1:0];
                CSR_N_IDX:   n_idx_q   <= wdata[IDX_W-1:0];
                CSR_K_IDX:   k_idx_q   <= wdata[IDX_W-1:0];
                CSR_BUFF:    buff_q    <= wdata[BUFF_W-1:0];
                CSR_SA:      sa_q      <= wdata[SCALE_W-1:0];
                CSR_SW:      sw_q      <= wdata[SCALE_W-1:0];
                CSR_PKT_LEN: pkt_len_q <= wdata[PKT_W-1:0];
                CSR_CRC_EN:  crc_en_q  <= wdata[0];
                CSR_STATUS:  status_q  <= wdata[STATUS_W-1:0];
                default: ;
            endcase
        end
    end

    // Read mux depends on addr only.
    always_comb begin
        rdata = unmapped_val;
        case (addr)
            CSR_CTRL:    rdata = DATA_W'(ctrl_q);
            CSR_M:       rdata = DATA_W'(m_q);
            CSR_N:       rdata = DATA_W'(n_q);
            CSR_K:       rdata = DATA_W'(k_q);
            CSR_TM:      rdata = DATA_W'(tm_q);
            CSR_TN:      rdata = DATA_W'(tn_q);
            CSR_TK:      rdata = DATA_W'(tk_q);
            CSR_M_IDX:   rdata = DATA_W'(m_idx_q);
            CSR_N_IDX:   rdata = DATA_W'(n_idx_q);
            CSR_K_IDX:   rdata = DATA_W'(k_idx_q);
            CSR_BUFF:    rdata = DATA_W'(buff_q);
            CSR_SA:      rdata = sa_q;
            CSR_SW:      rdata = sw_q;
            CSR_PKT_LEN: rdata = DATA_W'(pkt_len_q);
            CSR_CRC_EN:  rdata = DATA_W'(crc_en_q);
            CSR_STATUS:  rdata = DATA_W'(status_q);
            default:     rdata = unmapped_val;
        endcase
    end

    assign ctrl          = ctrl_q;
    assign M             = m_q;
    assign N             = n_q;
    assign K             = k_q;
    assign Tm            = tm_q;
    assign Tn            = tn_q;
    assign Tk            = tk_q;
    assign m_idx         = m_idx_q;
    assign n_idx         = n_idx_q;
    assign k_idx         = k_idx_q;
    assign bank_sel_wr_A = buff_q[0];
    assign bank_sel_wr_B = buff_q[1];
    assign bank_sel_rd_A = buff_q[2];
    assign bank_sel_rd_B = buff_q[3];
    assign Sa            = sa_q[7:0];
    assign Sw            = sw_q[7:0];
    assign pkt_len_max   = pkt_len_q;
    assign crc_en        = crc_en_q;
    assign status        = status_q;

endmodule

// File: tb/tb_csr.sv
// Directed self-checking bench for csr.
module tb_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  ctrl;
    logic [7:0]  M, N, K, Tm, Tn, Tk;
    logic [15:0] m_idx, n_idx, k_idx;
    logic        bank_sel_wr_A, bank_sel_wr_B, bank_sel_rd_A, bank_sel_rd_B;
    logic [7:0]  Sa, Sw;
    logic [15:0] pkt_len_max;
    logic        crc_en;
    logic [2:0]  status;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] unm_exp;
    logic [31:0] rst_exp;

    csr dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ctrl(ctrl),
        .M(M), .N(N), .K(K), .Tm(Tm), .Tn(Tn), .Tk(Tk),
        .m_idx(m_idx), .n_idx(n_idx), .k_idx(k_idx),
        .bank_sel_wr_A(bank_sel_wr_A), .bank_sel_wr_B(bank_sel_wr_B),
        .bank_sel_rd_A(bank_sel_rd_A), .bank_sel_rd_B(bank_sel_rd_B),
        .Sa(Sa), .Sw(Sw), .pkt_len_max(pkt_len_max), .crc_en(crc_en),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a write away from the edge, leave the bench 1 time unit past the capturing edge.
    task automatic write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
`ifdef CSR_UNMAPPED_DEADBEEF_EN
        unm_exp = 32'hDEADBEEF;
`else
        unm_exp = 32'h0;
`endif
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 8'h00;
        wdata = 32'h0;
        #12;

        for (int a = 0; a <= 8'h3C; a += 4) begin
            rst_exp = (a == 8'h34) ? 32'd256 : 32'd0;
            read_check($sformatf("reset_rd_%02h", a), 8'(a), rst_exp);
        end
        check("reset_pkt_len_max", 32'(pkt_len_max), 32'd256);

        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;

        write(8'h00, 32'd5);
        check("ctrl_rd", rdata, 32'd5);
        check("ctrl_out", 32'(ctrl), 32'd5);

        write(8'h00, 32'hFFFF_FFFA);
        check("ctrl_trunc", rdata, 32'd2);

        write(8'h04, 32'd7);
        check("M_rd", rdata, 32'd7);
        write(8'h08, 32'd11);
        check("N_rd", rdata, 32'd11);
        write(8'h0C, 32'h0000_0116);
        check("K_rd_trunc", rdata, 32'd22);
        check("M_out", 32'(M), 32'd7);
        check("N_out", 32'(N), 32'd11);
        check("K_out", 32'(K), 32'd22);

        write(8'h1C, 32'hABCD_1234);
        check("m_idx_rd", rdata, 32'h0000_1234);
        check("m_idx_out", 32'(m_idx), 32'h1234);

        write(8'h2C, 32'h42AA_0000);
        check("Sa_rd", rdata, 32'h42AA_0000);
        check("Sa_out", 32'(Sa), 32'h00);
        write(8'h30, 32'h1234_56C3);
        check("Sw_out", 32'(Sw), 32'hC3);

        write(8'h28, 32'hFFFF_FFFD);
        check("buff_rd", rdata, 32'hD);
        check("bank_sel", {28'h0, bank_sel_rd_B, bank_sel_rd_A, bank_sel_wr_B, bank_sel_wr_A}, 32'hD);

        write(8'h34, 32'd1234);
        write(8'h38, 32'd1);
        check("pkt_len_out", 32'(pkt_len_max), 32'd1234);
        check("crc_en_out", 32'(crc_en), 32'd1);
        read_check("pkt_len_rd", 8'h34, 32'd1234);

        write(8'h3C, 32'd6);
        check("status_out", 32'(status), 32'd6);

        // Same-address read during write: old before the edge, new after.
        write(8'h10, 32'd9);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 8'h10;
        wdata = 32'd33;
        #1;
        check("rw_old", rdata, 32'd9);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("rw_new", rdata, 32'd33);
        check("Tm_out", 32'(Tm), 32'd33);

        write(8'h06, 32'hFFFF_FFFF);
        write(8'h40, 32'hFFFF_FFFF);
        write(8'h01, 32'hFFFF_FFFF);
        read_check("unm_rd_06", 8'h06, unm_exp);
        read_check("unm_rd_40", 8'h40, unm_exp);
        read_check("unm_rd_ff", 8'hFF, unm_exp);
        read_check("unm_keep_ctrl", 8'h00, 32'd2);
        read_check("unm_keep_M", 8'h04, 32'd7);
        read_check("unm_keep_Sa", 8'h2C, 32'h42AA_0000);

        // Asynchronous reset mid-cycle, with a write attempted while held.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", 32'(ctrl), 32'd0);
        check("arst_M", 32'(M), 32'd0);
        check("arst_pkt_len", 32'(pkt_len_max), 32'd256);
        check("arst_crc_en", 32'(crc_en), 32'd0);
        check("arst_status", 32'(status), 32'd0);
        write(8'h00, 32'd7);
        check("arst_wr_ignored", 32'(ctrl), 32'd0);
        read_check("arst_rd_sa", 8'h2C, 32'd0);
        read_check("arst_rd_pkt", 8'h34, 32'd256);

        @(negedge clk);
        rst_n = 1'b1;
        write(8'h00, 32'd3);
        check("post_rst_ctrl", 32'(ctrl), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/csr.md
CSR -- requirements
Module: csr

Interface
REQ-001 Parameter PKT_LEN_RST, default 16'd256, SHALL be the reset value of pkt_len_max.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset; asynchronous, active-low.
REQ-004 Port wr_en, input, 1, SHALL be the write strobe, sampled at the rising edge of clk.
REQ-005 Port rd_en, input, 1, SHALL be the read strobe; it has no side effects.
REQ-006 Port addr, input, 8, SHALL be the byte address of a 32-bit register.
REQ-007 Port wdata, input, 32, SHALL be the write data.
REQ-008 Port rdata, output, 32, SHALL be the read data.
REQ-009 Port ctrl, output, 3, SHALL be the control field.
REQ-010 Ports M, N, K, Tm, Tn, Tk, output, 8 each, SHALL be the problem and tile dimensions.
REQ-011 Ports m_idx, n_idx, k_idx, output, 16 each, SHALL be the tile indices.
REQ-012 Ports bank_sel_wr_A, bank_sel_wr_B, bank_sel_rd_A, bank_sel_rd_B, output, 1 each, SHALL be the buffer bank selects.
REQ-013 Ports Sa and Sw, output, 8 each, SHALL be bits [7:0] of the 32-bit scale registers.
REQ-014 Port pkt_len_max, output, 16, SHALL be the maximum packet length; port crc_en, output, 1, SHALL be the CRC enable.
REQ-015 Port status, output, 3, SHALL be the status field.

Function
REQ-016 The register map SHALL be as follows (word-aligned byte addresses):
- 0x00 CTRL[2:0]
- 0x04 M, 0x08 N, 0x0C K, 0x10 Tm, 0x14 Tn, 0x18 Tk, each [7:0]
- 0x1C m_idx, 0x20 n_idx, 0x24 k_idx, each [15:0]
- 0x28 BUFF[3:0]
- 0x2C Sa[31:0], 0x30 Sw[31:0]
- 0x34 pkt_len_max[15:0]
- 0x38 crc_en[0]
- 0x3C STATUS[2:0]
REQ-017 The BUFF register SHALL drive bit0 to bank_sel_wr_A, bit1 to bank_sel_wr_B, bit2 to bank_sel_rd_A and bit3 to bank_sel_rd_B.
REQ-018 A write SHALL occur at the rising edge of clk when wr_en=1; the addressed register captures wdata truncated to its field width and discards the upper bits.
REQ-019 rdata SHALL be a combinational function of addr alone (independent of rd_en): the field value, zero-extended to 32 bits.
REQ-020 A write SHALL be visible on rdata and on the field outputs immediately after the writing edge (zero latency).
REQ-021 When wr_en and rd_en are asserted in the same cycle to the same address, rdata SHALL show the old value before the edge and the new value after it.
REQ-022 An address with addr[1:0]!=0, or in the range 0x40-0xFF, SHALL be unmapped: writes are ignored and reads return 0 (see REQ-026).
REQ-023 All field outputs SHALL be driven directly from the registers, with no gating by rd_en or wr_en.

Reset
REQ-024 While rst_n=0 (asynchronous assertion), every register SHALL be 0 except pkt_len_max, which SHALL be PKT_LEN_RST; the outputs SHALL follow immediately.
REQ-025 A wr_en pulse coinciding with reset SHALL be ignored; reset deassertion SHALL be synchronous to clk.

Configuration
REQ-026 The macro CSR_UNMAPPED_DEADBEEF_EN SHALL control unmapped reads: when it is defined, reads of unmapped addresses return 32'hDEADBEEF; when it is undefined, they return 32'h0. Writes to unmapped addresses are ignored in both cases.

Structure
REQ-027 Package csr_pkg SHALL hold the address localparams (CSR_CTRL..CSR_STATUS), the field widths and the reset constants.
REQ-028 The block SHALL be a single module with no sub-modules; the decode and the read mux are case statements on addr.

Verification
REQ-029 A bench SHALL cover the following directed scenarios:
- Reset: read 0x00-0x3C -> all 0, except 0x34 = 256.
- Write 0x00=5 -> rdata[2:0]=3'b101 and ctrl=5.
- Write 0x04=7, 0x08=11, 0x0C=22 -> rdata and M/N/K = 7/11/22.
- Write 0x2C=32'h42AA0000 -> rdata=32'h42AA0000 and Sa=8'h00.
- Write 0x28=4'b1101 -> bank_sel_wr_A=1, bank_sel_wr_B=0, bank_sel_rd_A=1, bank_sel_rd_B=1.
- Write 0x34=1234 and 0x38=1 -> pkt_len_max=1234 and crc_en=1.
- Write 0x3C=3'b110 -> status=6.
- Write 0x06 or 0x40 -> no register changes; read = 0 (or DEADBEEF when the macro is defined).
- Assert rst_n mid-sequence -> all registers return to their reset values asynchronously.
